// File: rtl/part2_regbank_if.sv
// part2_regbank_if: control/data bundle between the control unit and the
// register bank.
//   master : control unit side (drives selects, enables and write data,
//            receives read-port data and IR contents)
//   slave  : register bank side
// Signals: rf_in, rf_o1_sel, rf_o2_sel, rf_fun_sel, rf_reg_sel, rf_t_sel,
//          rf_o1, rf_o2, ir_in, ir_lh, ir_enable, ir_fun_sel, ir_out.
interface part2_regbank_if #(
  parameter int DATA_W = 8
);
  localparam int IR_W = 2 * DATA_W;

  logic [DATA_W-1:0] rf_in;
  logic [2:0]        rf_o1_sel;
  logic [2:0]        rf_o2_sel;
  logic [1:0]        rf_fun_sel;
  logic [3:0]        rf_reg_sel;
  logic [3:0]        rf_t_sel;
  logic [DATA_W-1:0] rf_o1;
  logic [DATA_W-1:0] rf_o2;
  logic [DATA_W-1:0] ir_in;
  logic              ir_lh;
  logic              ir_enable;
  logic [1:0]        ir_fun_sel;
  logic [IR_W-1:0]   ir_out;

  modport master (
    output rf_in, rf_o1_sel, rf_o2_sel, rf_fun_sel, rf_reg_sel, rf_t_sel,
    output ir_in, ir_lh, ir_enable, ir_fun_sel,
    input  rf_o1, rf_o2, ir_out
  );

  modport slave (
    input  rf_in, rf_o1_sel, rf_o2_sel, rf_fun_sel, rf_reg_sel, rf_t_sel,
    input  ir_in, ir_lh, ir_enable, ir_fun_sel,
    output rf_o1, rf_o2, ir_out
  );
endinterface

// File: rtl/part2_regbank.sv
// part2_regbank: 8-entry register file (T1-T4, R1-R4) with two combinational
// read ports, plus a 16-bit instruction register loaded a byte at a time.
// Every storage element is a part2_funreg (clear / load / dec / inc).
// Ports:
//   clock   : rising-edge clock
//   reset_n : async active-low reset, clears all registers
//   bus     : part2_regbank_if.slave (selects, enables, data, outputs)

// Generic function register. fun: 00 clear, 01 load, 10 dec, 11 inc.
// Arithmetic wraps modulo 2^W.
module part2_funreg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [1:0]   fun_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (fun_i)
        2'b00:   q_d = '0;
        2'b01:   q_d = d_i;
        2'b10:   q_d = q_q - W'(1);
        default: q_d = q_q + W'(1);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module part2_regbank #(
  parameter int DATA_W = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  part2_regbank_if.slave  bus
);
  localparam int IR_W    = 2 * DATA_W;
  localparam int NUM_REG = 8;

  // Entry index equals the read-select code: 0..3 = T1..T4, 4..7 = R1..R4.
  logic [NUM_REG-1:0][DATA_W-1:0] rf_q;
  logic [NUM_REG-1:0]             rf_en;

  for (genvar k = 0; k < NUM_REG; k++) begin : g_rf
    // Enable vectors are MSB-first (bit3 = T1/R1), hence the reversal.
    if (k < 4) begin : g_t
      assign rf_en[k] = bus.rf_t_sel[3-k];
    end else begin : g_r
      assign rf_en[k] = bus.rf_reg_sel[7-k];
    end

    part2_funreg #(.W(DATA_W)) u_reg (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .en_i   (rf_en[k]),
      .fun_i  (bus.rf_fun_sel),
      .d_i    (bus.rf_in),
      .q_o    (rf_q[k])
    );
  end

  assign bus.rf_o1 = rf_q[bus.rf_o1_sel];
  assign bus.rf_o2 = rf_q[bus.rf_o2_sel];

  // IR: a byte load is a full-width load of the new byte merged with the
  // untouched half; dec/inc/clear act on the whole 16 bits.
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] ir_ld;

  assign ir_ld = bus.ir_lh ? {bus.ir_in, ir_q[DATA_W-1:0]}
                           : {ir_q[IR_W-1:DATA_W], bus.ir_in};

  part2_funreg #(.W(IR_W)) u_ir (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .en_i   (bus.ir_enable),
    .fun_i  (bus.ir_fun_sel),
    .d_i    (ir_ld),
    .q_o    (ir_q)
  );

  assign bus.ir_out = ir_q;
endmodule

// File: tb/tb_part2_regbank.sv
// tb_part2_regbank: directed walk-through plus randomized stimulus for
// part2_regbank, checked against an array/integer reference model.
module tb_part2_regbank;
  logic clock = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;

  // Reference state: index = read-select code (0..3 T1..T4, 4..7 R1..R4).
  int m_rf [8];
  int m_ir;

  part2_regbank_if #(.DATA_W(8)) bif ();

  part2_regbank #(.DATA_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int fn_apply(input int v, input int fun, input int d, input int mask);
    case (fun)
      0:       return 0;
      1:       return d & mask;
      2:       return (v - 1) & mask;
      default: return (v + 1) & mask;
    endcase
  endfunction

  // Check every register through both ports, and the IR.
  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      bif.rf_o1_sel = 3'(i);
      bif.rf_o2_sel = 3'(7 - i);
      #1;
      chk($sformatf("rf_o1[%0d]", i), 16'(bif.rf_o1), 16'(m_rf[i]));
      chk($sformatf("rf_o2[%0d]", 7 - i), 16'(bif.rf_o2), 16'(m_rf[7 - i]));
    end
    chk("ir_out", bif.ir_out, 16'(m_ir));
  endtask

  // One clock edge: update the model from the applied controls, then check.
  task automatic tick();
    int en;
    @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      en = (i < 4) ? int'(bif.rf_t_sel[3 - i]) : int'(bif.rf_reg_sel[7 - i]);
      if (en != 0) m_rf[i] = fn_apply(m_rf[i], bif.rf_fun_sel, bif.rf_in, 'hFF);
    end
    if (bif.ir_enable) begin
      if (bif.ir_fun_sel == 2'b01)
        m_ir = bif.ir_lh ? ((m_ir & 'h00FF) | (int'(bif.ir_in) << 8))
                         : ((m_ir & 'hFF00) | int'(bif.ir_in));
      else
        m_ir = fn_apply(m_ir, bif.ir_fun_sel, 0, 'hFFFF);
    end
    #1;
    sweep();
  endtask

  task automatic rd(input string tag, input logic [2:0] s1, input logic [2:0] s2,
                    input logic [7:0] e1, input logic [7:0] e2);
    bif.rf_o1_sel = s1;
    bif.rf_o2_sel = s2;
    #1;
    chk({tag, "_o1"}, 16'(bif.rf_o1), 16'(e1));
    chk({tag, "_o2"}, 16'(bif.rf_o2), 16'(e2));
  endtask

  task automatic rf_set(input logic [1:0] fun, input logic [3:0] rs,
                        input logic [3:0] ts, input logic [7:0] d);
    bif.rf_fun_sel = fun; bif.rf_reg_sel = rs; bif.rf_t_sel = ts; bif.rf_in = d;
  endtask

  task automatic ir_set(input logic en, input logic [1:0] fun,
                        input logic lh, input logic [7:0] d);
    bif.ir_enable = en; bif.ir_fun_sel = fun; bif.ir_lh = lh; bif.ir_in = d;
  endtask

  // Mid-cycle async reset: outputs must clear with no clock edge.
  task automatic reset_pulse();
    @(negedge clock);
    #3;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_ir = 0;
    bif.rf_o1_sel = 3'b100;
    bif.rf_o2_sel = 3'b011;
    #1;
    chk("rst_o1", 16'(bif.rf_o1), 16'h0);
    chk("rst_o2", 16'(bif.rf_o2), 16'h0);
    chk("rst_ir", bif.ir_out, 16'h0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    rf_set(2'b00, 4'b0000, 4'b0000, 8'h00);
    ir_set(1'b0, 2'b00, 1'b0, 8'h00);
    bif.rf_o1_sel = 3'b000;
    bif.rf_o2_sel = 3'b111;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_ir = 0;
    #25;
    sweep();
    @(negedge clock);
    reset_n = 1'b1;

    // RF load / dec / inc
    rf_set(2'b01, 4'b1111, 4'b1111, 8'h05); tick();
    rd("ld5", 3'b100, 3'b000, 8'h05, 8'h05);
    rf_set(2'b10, 4'b1000, 4'b1000, 8'h00); tick();
    rd("dec", 3'b100, 3'b000, 8'h04, 8'h04);
    rf_set(2'b11, 4'b0100, 4'b0100, 8'h00); tick();
    rd("inc", 3'b101, 3'b001, 8'h06, 8'h06);
    rd("hold", 3'b100, 3'b000, 8'h04, 8'h04);

    // Retain / clear
    rf_set(2'b01, 4'b0000, 4'b0000, 8'hFF); tick();
    rd("ret", 3'b110, 3'b010, 8'h05, 8'h05);
    rf_set(2'b00, 4'b1111, 4'b1111, 8'h00); tick();
    rd("clr", 3'b111, 3'b011, 8'h00, 8'h00);

    // Wrap-around on R4
    rf_set(2'b10, 4'b0001, 4'b0000, 8'h00); tick();
    rd("wrapd", 3'b111, 3'b110, 8'hFF, 8'h00);
    rf_set(2'b11, 4'b0001, 4'b0000, 8'h00); tick();
    rd("wrapi", 3'b111, 3'b111, 8'h00, 8'h00);
    rf_set(2'b00, 4'b0000, 4'b0000, 8'h00);

    // IR byte loads and 16-bit arithmetic
    ir_set(1'b1, 2'b01, 1'b0, 8'h00); tick();
    ir_set(1'b1, 2'b01, 1'b1, 8'hFF); tick();
    chk("ir_ff00", bif.ir_out, 16'hFF00);
    ir_set(1'b1, 2'b11, 1'b1, 8'h00); tick();
    chk("ir_ff01", bif.ir_out, 16'hFF01);
    ir_set(1'b1, 2'b10, 1'b0, 8'h00); tick();
    chk("ir_ff00b", bif.ir_out, 16'hFF00);
    ir_set(1'b1, 2'b01, 1'b1, 8'h00); tick();
    ir_set(1'b1, 2'b01, 1'b0, 8'hFF); tick();
    chk("ir_00ff", bif.ir_out, 16'h00FF);
    ir_set(1'b1, 2'b11, 1'b0, 8'h00); tick();
    chk("ir_carry", bif.ir_out, 16'h0100);
    ir_set(1'b0, 2'b10, 1'b0, 8'h00); tick();
    chk("ir_hold", bif.ir_out, 16'h0100);
    ir_set(1'b1, 2'b00, 1'b0, 8'h00); tick();
    chk("ir_clr", bif.ir_out, 16'h0000);

    // Load everything, then async reset mid-cycle
    rf_set(2'b01, 4'b1111, 4'b1111, 8'hA5);
    ir_set(1'b1, 2'b01, 1'b1, 8'h3C); tick();
    ir_set(1'b0, 2'b00, 1'b0, 8'h00);
    reset_pulse();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rf_set(2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
      ir_set(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
      tick();
      if ($urandom_range(0, 59) == 0) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
